pipe_ctrl: RTL

- Pipeline control unit for the five-stage Y86 core.
- Owns the F_predPC register that feeds fetch, and detects load/use, ret and mispredicted-jump hazards.
- Drives stall/bubble/set_cc for every pipeline register.
- Runs a run/halt state machine that freezes the machine on a non-AOK writeback status; perf counters are optional.

---
 rtl/y86_pkg.sv | 21 ++
 rtl/pipe_hazard_detect.sv | 26 ++
 rtl/pipe_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 icodes, status codes and pipeline-control state encoding
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;
  typedef enum logic [1:0] {FLUSH, RUN, HALTED} ctrl_state_t;
endpackage

// File: rtl/pipe_hazard_detect.sv
// pipe_hazard_detect: combinational load/use, ret, mispredict and exception terms
module pipe_hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] d_icode_i,
  input  logic [3:0] e_icode_i,
  input  logic [3:0] m_icode_i,
  input  logic [3:0] e_dstm_i,
  input  logic [3:0] d_srca_i,
  input  logic [3:0] d_srcb_i,
  input  logic       e_cnd_i,
  input  logic [2:0] m_stat_i,
  input  logic [2:0] w_stat_i,
  output logic       lu_o,
  output logic       rt_o,
  output logic       mp_o,
  output logic       ex_m_o,
  output logic       ex_w_o
);
  assign lu_o   = (e_icode_i == IMRMOVQ || e_icode_i == IPOPQ) && e_dstm_i != RNONE &&
                  (e_dstm_i == d_srca_i || e_dstm_i == d_srcb_i);
  assign rt_o   = d_icode_i == IRET || e_icode_i == IRET || m_icode_i == IRET;
  assign mp_o   = e_icode_i == IJXX && !e_cnd_i;
  assign ex_m_o = m_stat_i != SAOK;
  assign ex_w_o = w_stat_i != SAOK;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86 pipeline control (FSM, F_predPC, stall/bubble); perf counters under PIPE_CTRL_PERF_CNT_EN
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int              PC_W      = 64,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              FLUSH_CYC = 3,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  input  logic [PC_W-1:0]  f_predPC,
  output logic [PC_W-1:0]  F_predPC,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             set_cc,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  ctrl_state_t     state_q, state_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      stat_q, stat_d;
  logic            halted_q, halted_d;
  logic            lu, rt, mp, ex_m, ex_w, run, to_halt;

  pipe_hazard_detect u_hz (
    .d_icode_i(D_icode), .e_icode_i(E_icode), .m_icode_i(M_icode),
    .e_dstm_i(E_dstM), .d_srca_i(d_srcA), .d_srcb_i(d_srcB),
    .e_cnd_i(e_cnd), .m_stat_i(m_stat), .w_stat_i(W_stat),
    .lu_o(lu), .rt_o(rt), .mp_o(mp), .ex_m_o(ex_m), .ex_w_o(ex_w)
  );

  assign run     = state_q == RUN;
  assign to_halt = run && ex_w;

  // state register
  always_ff @(posedge clk)
    state_q <= rst ? FLUSH : state_d;

  // next state: flush countdown, then run until writeback reports an exception
  always_comb
    state_d = state_q == FLUSH ? (flush_cnt_q == FW'(FLUSH_CYC - 1) ? RUN : FLUSH) :
              run ? (ex_w ? HALTED : RUN) : HALTED;

  // stage controls; FLUSH and HALTED force fixed patterns
  always_comb begin
    F_stall  = run ? (lu | rt) : 1'b1;
    D_stall  = run ? lu : state_q == HALTED;
    D_bubble = run ? (mp | (rt & !lu)) : state_q == FLUSH;
    E_bubble = run ? (mp | lu) : 1'b1;
    M_bubble = run ? (ex_m | ex_w) : 1'b1;
    W_stall  = run ? ex_w : state_q == HALTED;
    set_cc   = run && E_icode == IOPQ && !ex_m && !ex_w;
  end

  // datapath next values; the oldest (writeback) status is the one latched
  always_comb begin
    flush_cnt_d = state_q == FLUSH ? flush_cnt_q + FW'(1) : flush_cnt_q;
    pc_d        = F_stall ? pc_q : f_predPC;
    stat_d      = to_halt ? W_stat : stat_q;
    halted_d    = halted_q | to_halt;
  end

  // datapath registers
  always_ff @(posedge clk)
    if (rst) begin
      flush_cnt_q <= '0;
      pc_q        <= RESET_PC;
      stat_q      <= SAOK;
      halted_q    <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      pc_q        <= pc_d;
      stat_q      <= stat_d;
      halted_q    <= halted_d;
    end

  assign F_predPC = pc_q;
  assign cpu_stat = stat_q;
  assign halted   = halted_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, stl_q, stl_d, bub_q, bub_d;

  // saturating increments, active only while running
  always_comb begin
    cyc_d = cyc_q + CNT_W'(run && !(&cyc_q));
    ret_d = ret_q + CNT_W'(run && W_stat == SAOK && W_icode != INOP && !(&ret_q));
    stl_d = stl_q + CNT_W'(run && F_stall && !(&stl_q));
    bub_d = bub_q + CNT_W'(run && E_bubble && !(&bub_q));
  end

  // perf counter registers
  always_ff @(posedge clk)
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
      stl_q <= '0;
      bub_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
      stl_q <= stl_d;
      bub_q <= bub_d;
    end

  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
  assign stall_cnt   = stl_q;
  assign bubble_cnt  = bub_q;
`else
  logic unused_w;
  assign unused_w    = ^W_icode;
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
  assign bubble_cnt  = '0;
`endif
endmodule
